// File: rtl/key_debounce_if.sv
// Interface bundling the key inputs and the debounced outputs of key_debounce.
// master: the side that drives the raw pins and reads the clean levels (board / bench).
// slave : the debouncer itself.
// The edge-capture signals exist only when KEY_EDGE_CAPTURE_EN is defined.
interface key_debounce_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] key_raw;
    logic [WIDTH-1:0] key_db;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
`ifdef KEY_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] clr_capture;
    logic [WIDTH-1:0] edge_capture;
    logic             key_irq;

    modport master (
        output key_raw,
        output clr_capture,
        input  key_db,
        input  press_pulse,
        input  release_pulse,
        input  edge_capture,
        input  key_irq
    );

    modport slave (
        input  key_raw,
        input  clr_capture,
        output key_db,
        output press_pulse,
        output release_pulse,
        output edge_capture,
        output key_irq
    );
`else
    modport master (
        output key_raw,
        input  key_db,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  key_raw,
        output key_db,
        output press_pulse,
        output release_pulse
    );
`endif
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchroniser + per-key debounce counter + press/release strobes for the
// active-low DE1-SoC push buttons. key_db feeds the KEY PIO in_port (1 = released).
// Optional sticky press capture with interrupt output: define KEY_EDGE_CAPTURE_EN.
// Constraints: DEBOUNCE_CYCLES >= 2, 2**CNT_W > DEBOUNCE_CYCLES, and the interface
// WIDTH must equal this module's WIDTH.
module key_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic          clk,
    input  logic          reset,
    key_debounce_if.slave bus
);

    // Terminal count: a change is accepted on the edge that sees the counter here while
    // s2 still differs, i.e. after DEBOUNCE_CYCLES consecutive differing samples of s2.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchroniser; nothing may be inserted between the stages.
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Debounced level and its single-cycle change strobes (all registered).
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;

    // Per-key stability counters.
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Per-key debounce decision: count while s2 disagrees with key_db, accept at terminal.
    always_comb begin
        db_d      = db_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    // Accept: counter returns to 0 so it never exceeds CntMax or wraps.
                    db_d[i]      = s2_q[i];
                    press_d[i]   = ~s2_q[i];
                    release_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            // s2 == key_db: any bounce back to the accepted level restarts the count.
        end
    end

    // Synchroniser, counters, debounced level and strobes; reset forces "all released".
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '1;
            s2_q      <= '1;
            db_q      <= '1;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= bus.key_raw;
            s2_q      <= s1_q;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.key_db        = db_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;

`ifdef KEY_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] capture_q, capture_d;
    logic             irq_q;

    // Sticky press flags: set by the visible press strobe, cleared per bit; set wins.
    always_comb begin
        capture_d = (capture_q & ~bus.clr_capture) | press_q;
    end

    // Capture register and its OR-reduced interrupt, updated on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            capture_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            capture_q <= capture_d;
            irq_q     <= |capture_d;
        end
    end

    assign bus.edge_capture = capture_q;
    assign bus.key_irq      = irq_q;
`endif

endmodule
